mmcm_reset_sequencer: RTL and testbench



---
 rtl/mmcm_seq_pkg.sv | 28 ++
 rtl/sync_signal.sv | 16 +
 rtl/mmcm_reset_sequencer.sv | 94 +++++++++
 tb/tb_mmcm_reset_sequencer.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mmcm_seq_pkg.sv
// mmcm_seq_pkg: state encoding, default parameters and sizing helper for mmcm_reset_sequencer
package mmcm_seq_pkg;
    localparam logic [2:0] ST_ASSERT    = 3'd0;
    localparam logic [2:0] ST_WAIT_LOCK = 3'd1;
    localparam logic [2:0] ST_STABLE    = 3'd2;
    localparam logic [2:0] ST_RUN       = 3'd3;
    localparam logic [2:0] ST_FAULT     = 3'd4;

    typedef enum logic [2:0] {
        ASSERT    = ST_ASSERT,
        WAIT_LOCK = ST_WAIT_LOCK,
        STABLE    = ST_STABLE,
        RUN       = ST_RUN,
        FAULT     = ST_FAULT
    } state_t;

    localparam int DEF_RST_PULSE_CYCLES    = 16;
    localparam int DEF_LOCK_TIMEOUT_CYCLES = 65536;
    localparam int DEF_LOCK_STABLE_CYCLES  = 1024;
    localparam int DEF_MAX_RETRIES         = 7;
    localparam int DEF_SYNC_STAGES         = 3;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction
endpackage

// File: rtl/sync_signal.sv
// sync_signal: N-stage single-bit synchronizer, cleared by synchronous reset
module sync_signal #(
    parameter int STAGES = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic [STAGES-1:0] ff;

    always_ff @(posedge clk)
        ff <= rst ? '0 : {ff[STAGES-2:0], d};

    assign q = ff[STAGES-1];
endmodule

// File: rtl/mmcm_reset_sequencer.sv
// mmcm_reset_sequencer: pulses MMCM reset, qualifies LOCKED, releases downstream reset.
// Define MMCM_SEQ_RETRY_EN to retry failed lock attempts; otherwise failures go straight to FAULT.
module mmcm_reset_sequencer
    import mmcm_seq_pkg::*;
#(
    parameter int RST_PULSE_CYCLES    = DEF_RST_PULSE_CYCLES,
    parameter int LOCK_TIMEOUT_CYCLES = DEF_LOCK_TIMEOUT_CYCLES,
    parameter int LOCK_STABLE_CYCLES  = DEF_LOCK_STABLE_CYCLES,
    parameter int MAX_RETRIES         = DEF_MAX_RETRIES,
    parameter int SYNC_STAGES         = DEF_SYNC_STAGES
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               locked_in,
    output logic                               mmcm_rst,
    output logic                               rst_out,
    output logic                               ready,
    output logic                               fault,
    output logic                               lock_lost,
    output logic [$clog2(MAX_RETRIES+1)-1:0]   retry_count,
    output logic [2:0]                         state_dbg
);
    localparam int RW = $clog2(MAX_RETRIES + 1);
    localparam int CW = $clog2(max3(RST_PULSE_CYCLES, LOCK_TIMEOUT_CYCLES, LOCK_STABLE_CYCLES)) + 1;

    state_t          state, nxt;
    logic [CW-1:0]   cnt;
    logic [RW-1:0]   retry_nxt;
    logic            lost_nxt, fail, locked_sync;

    sync_signal #(.STAGES(SYNC_STAGES)) u_sync (
        .clk (clk),
        .rst (rst),
        .d   (locked_in),
        .q   (locked_sync)
    );

    always_comb begin
        nxt       = state;
        retry_nxt = retry_count;
        lost_nxt  = lock_lost;
        fail      = 1'b0;
        case (state)
            ASSERT:    nxt = (cnt == CW'(RST_PULSE_CYCLES - 1)) ? WAIT_LOCK : ASSERT;
            WAIT_LOCK: begin
                nxt  = locked_sync ? STABLE : WAIT_LOCK;
                fail = !locked_sync && cnt == CW'(LOCK_TIMEOUT_CYCLES - 1);
            end
            // a drop on the completing cycle must win over promotion to RUN
            STABLE: begin
                fail = !locked_sync;
                nxt  = (locked_sync && cnt == CW'(LOCK_STABLE_CYCLES - 1)) ? RUN : STABLE;
            end
            RUN: if (!locked_sync) begin
                nxt       = ASSERT;
                lost_nxt  = 1'b1;
                retry_nxt = '0;
            end
            default: ;
        endcase
        if (fail) begin
`ifdef MMCM_SEQ_RETRY_EN
            nxt       = (retry_count < RW'(MAX_RETRIES)) ? ASSERT : FAULT;
            retry_nxt = (retry_count < RW'(MAX_RETRIES)) ? retry_count + 1'b1 : retry_count;
`else
            nxt = FAULT;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ASSERT;
            cnt         <= '0;
            retry_count <= '0;
            lock_lost   <= 1'b0;
            mmcm_rst    <= 1'b1;
            rst_out     <= 1'b1;
            ready       <= 1'b0;
            fault       <= 1'b0;
        end else begin
            state       <= nxt;
            cnt         <= (nxt != state) ? '0 : cnt + CW'(cnt != '1);
            retry_count <= retry_nxt;
            lock_lost   <= lost_nxt;
            mmcm_rst    <= nxt == ASSERT;
            rst_out     <= nxt != RUN;
            ready       <= nxt == RUN;
            fault       <= nxt == FAULT;
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_mmcm_reset_sequencer.sv
// tb_mmcm_reset_sequencer: directed scenarios plus random LOCKED traffic against a per-cycle reference model
module tb_mmcm_reset_sequencer;
    localparam int P  = 4;
    localparam int T  = 32;
    localparam int S  = 8;
    localparam int R  = 2;
    localparam int SS = 2;
`ifdef MMCM_SEQ_RETRY_EN
    localparam int EXP_PULSES = R + 1;
    localparam int EXP_RC     = R;
`else
    localparam int EXP_PULSES = 1;
    localparam int EXP_RC     = 0;
`endif

    logic       clk, rst, locked_in;
    logic       mmcm_rst, rst_out, ready, fault, lock_lost;
    logic [1:0] retry_count;
    logic [2:0] state_dbg;

    int checks = 0;
    int errors = 0;
    bit rel_seen = 0;

    mmcm_reset_sequencer #(
        .RST_PULSE_CYCLES    (P),
        .LOCK_TIMEOUT_CYCLES (T),
        .LOCK_STABLE_CYCLES  (S),
        .MAX_RETRIES         (R),
        .SYNC_STAGES         (SS)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .locked_in   (locked_in),
        .mmcm_rst    (mmcm_rst),
        .rst_out     (rst_out),
        .ready       (ready),
        .fault       (fault),
        .lock_lost   (lock_lost),
        .retry_count (retry_count),
        .state_dbg   (state_dbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: phases numbered as the published state encoding, time-in-phase as an
    // unbounded int, and the synchronizer as "locked_in as sampled SS edges ago" from a history ring.
    typedef struct packed {
        int   ph;
        int   el;
        int   rc;
        logic lost;
    } mst_t;

    mst_t m;
    bit   m_valid = 0;
    int   k = 0;
    int   last_r = 0;
    bit   li_at [256];

    function automatic mst_t step(input mst_t s, input logic ls);
        mst_t n;
        bit   bad;
        n   = s;
        bad = 0;
        if (s.ph == 0 && s.el + 1 == P) n.ph = 1;
        if (s.ph == 1) begin
            if (ls) n.ph = 2;
            else if (s.el + 1 == T) bad = 1;
        end
        if (s.ph == 2) begin
            if (!ls) bad = 1;
            else if (s.el + 1 == S) n.ph = 3;
        end
        if (s.ph == 3 && !ls) begin
            n.ph   = 0;
            n.lost = 1'b1;
            n.rc   = 0;
        end
        if (bad) begin
`ifdef MMCM_SEQ_RETRY_EN
            if (s.rc < R) begin
                n.ph = 0;
                n.rc = s.rc + 1;
            end else n.ph = 4;
`else
            n.ph = 4;
`endif
        end
        n.el = (n.ph != s.ph) ? 0 : s.el + 1;
        return n;
    endfunction

    always @(posedge clk) begin
        li_at[k % 256] <= locked_in;
        k <= k + 1;
        if (rst) begin
            m       <= '{ph: 0, el: 0, rc: 0, lost: 1'b0};
            last_r  <= k;
            m_valid <= 1'b1;
        end else begin
            m <= step(m, (k - SS > last_r) ? li_at[(k - SS) % 256] : 1'b0);
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("cycle_model",
                  {mmcm_rst, rst_out, ready, fault, lock_lost, retry_count, state_dbg},
                  {m.ph == 0, m.ph != 3, m.ph == 3, m.ph == 4, m.lost, 2'(m.rc), 3'(m.ph)});
        end
        if (rst_out === 1'b0) rel_seen = 1;
    end

    function automatic logic probe(input int sel);
        case (sel)
            0:       return mmcm_rst;
            1:       return rst_out;
            2:       return ready;
            3:       return fault;
            default: return state_dbg == 3'(sel - 10);
        endcase
    endfunction

    task automatic expect_wait(input string name, input int sel, input logic val,
                               input int exp, input int limit);
        int n;
        n = 0;
        while (n < limit && probe(sel) !== val) begin
            @(negedge clk);
            n++;
        end
        if (exp >= 0) check(name, n, exp);
        else if (n >= limit) check(name, n, -1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        locked_in = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_values", {mmcm_rst, rst_out, ready, fault, lock_lost, retry_count, state_dbg},
              10'b11_0000_0000);

        // clean bring-up
        rst = 1'b0;
        expect_wait("first_pulse_width", 0, 1'b0, P, 50);
        repeat (10 - P) @(negedge clk);
        locked_in = 1'b1;
        expect_wait("lock_to_stable", 12, 1'b1, SS + 1, 50);
        expect_wait("stable_to_release", 1, 1'b0, S, 50);
        check("ready_in_run", ready, 1);
        check("retry_in_run", retry_count, 0);

        // loss of lock while running
        repeat (3) @(negedge clk);
        locked_in = 1'b0;
        expect_wait("loss_to_rst_out", 1, 1'b1, SS + 1, 50);
        check("lock_lost_set", lock_lost, 1);
        check("retry_cleared", retry_count, 0);
        check("mmcm_rst_on_loss", mmcm_rst, 1);
        expect_wait("loss_pulse_width", 0, 1'b0, P, 50);
        repeat (20 - (SS + 1) - P) @(negedge clk);
        locked_in = 1'b1;
        expect_wait("rerun_after_loss", 2, 1'b1, -1, 100);
        check("lock_lost_sticky", lock_lost, 1);

        // reset in the middle of the STABLE count
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expect_wait("reach_stable", 12, 1'b1, -1, 100);
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_values", {mmcm_rst, rst_out, ready, fault, lock_lost, retry_count, state_dbg},
              10'b11_0000_0000);
        rst = 1'b0;
        expect_wait("pulse_after_midrst", 0, 1'b0, P, 50);

        // lock never arrives
        rst = 1'b1;
        locked_in = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        for (int p = 0; p < EXP_PULSES; p++) begin
            expect_wait("nolock_pulse_width", 0, 1'b0, P, 50);
            if (p < EXP_PULSES - 1) expect_wait("nolock_wait", 0, 1'b1, T, 100);
        end
        expect_wait("nolock_fault", 3, 1'b1, T, 100);
        check("nolock_retry_count", retry_count, EXP_RC);
        check("nolock_rst_out", rst_out, 1);
        check("nolock_state", state_dbg, 4);

        // unstable lock: three short lock windows
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rel_seen = 0;
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            expect_wait("unstable_wait_lock", 0, 1'b0, -1, 100);
            locked_in = 1'b1;
            repeat (5) @(negedge clk);
            locked_in = 1'b0;
            repeat (SS + 1) @(negedge clk);
`ifdef MMCM_SEQ_RETRY_EN
            check("unstable_state", state_dbg, (i < 2) ? 0 : 4);
            check("unstable_retry", retry_count, (i < 2) ? i + 1 : 2);
`else
            check("unstable_state", state_dbg, 4);
            check("unstable_retry", retry_count, 0);
`endif
        end
        check("unstable_never_released", int'(rel_seen), 0);

        // random lock traffic with occasional resets
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int e = 0; e < 80; e++) begin
            if ($urandom_range(0, 9) == 0) begin
                rst = 1'b1;
                repeat ($urandom_range(1, 3)) @(negedge clk);
                rst = 1'b0;
            end else begin
                locked_in = ~locked_in;
                repeat ($urandom_range(1, 50)) @(negedge clk);
            end
        end
        repeat (5) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
